// File: rtl/mux_nto1_pipe_pkg.sv
// Shared constants and the channel slice helper for the N:1 pipelined mux.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_CH = 64;
    localparam int MAX_W  = 64;

    // Extracts channel k from a zero-extended flat bus; the caller truncates to WIDTH.
    function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_CH*MAX_W-1:0] d,
                                                  input int k,
                                                  input int width);
        logic [MAX_W-1:0] r;
        logic [11:0]      idx;
        r = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < width) begin
                idx  = 12'(k * width + b);
                r[b] = d[idx];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Channel-side and consumer-side handshake bundle of the N:1 mux.
// out_par only exists when MUX_PARITY_EN is defined.
interface mux_nto1_pipe_if #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] d_i;
    logic [N_CH-1:0]       in_vld;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_vld;
    logic                  out_ready;
`ifdef MUX_PARITY_EN
    logic                  out_par;

    modport master (output d_i, in_vld, out_ready,
                    input  in_ready, out_data, out_ch, out_vld, out_par);
    modport slave  (input  d_i, in_vld, out_ready,
                    output in_ready, out_data, out_ch, out_vld, out_par);
`else
    modport master (output d_i, in_vld, out_ready,
                    input  in_ready, out_data, out_ch, out_vld);
    modport slave  (input  d_i, in_vld, out_ready,
                    output in_ready, out_data, out_ch, out_vld);
`endif

endinterface

// File: rtl/mux_nto1_pipe_scan_ptr.sv
// Round-robin channel pointer: wraps N_CH-1 -> 0.
// Latency: advances one step per cycle with inc. No backpressure of its own.
// Holds its value whenever inc is low.
module mux_scan_ptr #(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [SEL_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == SEL_W'(N_CH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-channel registered mux with manual select or round-robin scan; optional parity via MUX_PARITY_EN.
// Latency: 1 cycle from capture to out_vld; one transfer per cycle at full throughput.
// Backpressure: when the output holds unaccepted data, all in_ready drop and the output holds.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             sel_vld,
    mux_nto1_pipe_if.slave   bus
);

    logic [SEL_W-1:0]        sel_q;
    logic [SEL_W-1:0]        scan_ptr;
    logic [SEL_W-1:0]        cur;
    logic                    free;
    logic                    capture;
    logic                    scan_inc;
    logic [WIDTH-1:0]        cur_dat;
    logic [MAX_CH*MAX_W-1:0] d_ext;

    assign cur     = (mode == MODE_SCAN) ? scan_ptr : sel_q;
    assign free    = !bus.out_vld || bus.out_ready;
    assign capture = free && bus.in_vld[cur];

    // Whenever the stage is free the scan either captures or skips an idle channel.
    assign scan_inc = (mode == MODE_SCAN) && free;

    // Nothing may be offered a handshake while reset is asserted.
    assign bus.in_ready = (free && rst_n) ? (N_CH'(1) << cur) : '0;

    always_comb begin
        d_ext                   = '0;
        d_ext[N_CH*WIDTH-1:0]   = bus.d_i;
        cur_dat                 = WIDTH'(ch_slice(d_ext, int'(cur), WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else if (mode == MODE_MANUAL && sel_vld && (32'(sel_i) < N_CH)) begin
            sel_q <= sel_i;
        end
    end

    mux_scan_ptr #(.N_CH(N_CH)) u_scan_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (scan_inc),
        .ptr   (scan_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch   <= '0;
`ifdef MUX_PARITY_EN
            bus.out_par  <= 1'b0;
`endif
        end else if (capture) begin
            bus.out_vld  <= 1'b1;
            bus.out_data <= cur_dat;
            bus.out_ch   <= cur;
`ifdef MUX_PARITY_EN
            bus.out_par  <= ^cur_dat;
`endif
        end else if (bus.out_ready) begin
            bus.out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Randomised and directed bench for mux_nto1_pipe (8x4 main instance, 6x4 instance for select range).
module tb_mux_nto1_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode, sel_vld, mode6, sel_vld6;
    logic [2:0] sel_i, sel_i6;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state for the 8-channel instance
    int         m_sel, m_ptr;
    bit         m_vld, m_par;
    logic [3:0] m_data;
    logic [2:0] m_ch;

    always #5 clk = ~clk;

    mux_nto1_pipe_if #(.N_CH(8), .WIDTH(4)) bus ();
    mux_nto1_pipe_if #(.N_CH(6), .WIDTH(4)) bus6 ();

    mux_nto1_pipe #(.N_CH(8), .WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_i(sel_i), .sel_vld(sel_vld), .bus(bus)
    );

    mux_nto1_pipe #(.N_CH(6), .WIDTH(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .sel_i(sel_i6), .sel_vld(sel_vld6), .bus(bus6)
    );

    task automatic model_reset();
        m_sel = 0; m_ptr = 0; m_vld = 0; m_par = 0; m_data = '0; m_ch = '0;
    endtask

    // One clock of the 8-channel instance against the model; inputs are already driven.
    task automatic step(input string tag);
        int         cur, n_sel, n_ptr;
        bit         free, cap, n_vld, n_par;
        logic [7:0] exp_rdy;
        logic [3:0] dsel, n_data;
        logic [2:0] n_ch;
        #1;
        cur     = mode ? m_ptr : m_sel;
        free    = !m_vld || bus.out_ready;
        cap     = free && bus.in_vld[cur];
        exp_rdy = free ? (8'b1 << cur) : 8'b0;
        dsel    = bus.d_i[cur*4 +: 4];
        n_checks++;
        if (bus.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b expected %b", tag, bus.in_ready, exp_rdy);
        end
        n_vld = m_vld; n_data = m_data; n_ch = m_ch; n_par = m_par;
        n_sel = m_sel; n_ptr = m_ptr;
        if (cap) begin
            n_vld = 1; n_data = dsel; n_ch = 3'(cur); n_par = ^dsel;
        end else if (bus.out_ready) begin
            n_vld = 0;
        end
        if (mode && (cap || (free && !bus.in_vld[cur]))) n_ptr = (m_ptr + 1) % 8;
        if (!mode && sel_vld && sel_i < 8) n_sel = int'(sel_i);
        @(posedge clk);
        #1;
        m_vld = n_vld; m_data = n_data; m_ch = n_ch; m_par = n_par;
        m_sel = n_sel; m_ptr = n_ptr;
        n_checks++;
        if (bus.out_vld !== m_vld) begin
            n_fail++;
            $display("FAIL %s out_vld: got %b expected %b", tag, bus.out_vld, m_vld);
        end
        if (m_vld) begin
            n_checks++;
            if (bus.out_data !== m_data || bus.out_ch !== m_ch) begin
                n_fail++;
                $display("FAIL %s out_data/out_ch: got %h/%0d expected %h/%0d",
                         tag, bus.out_data, bus.out_ch, m_data, m_ch);
            end
`ifdef MUX_PARITY_EN
            n_checks++;
            if (bus.out_par !== m_par) begin
                n_fail++;
                $display("FAIL %s out_par: got %b expected %b", tag, bus.out_par, m_par);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 0; sel_i = 0; sel_vld = 0; mode6 = 0; sel_i6 = 0; sel_vld6 = 0;
        bus.d_i = '0; bus.in_vld = '0; bus.out_ready = 1'b1;
        bus6.d_i = '0; bus6.in_vld = '0; bus6.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== 4'h0 || bus.out_ch !== 3'd0 || bus.in_ready !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: got vld=%b data=%h ch=%0d rdy=%b expected all zero",
                     bus.out_vld, bus.out_data, bus.out_ch, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
    endtask

    task automatic test_manual();
        logic [31:0] d;
        d = $urandom;
        d[23:20] = 4'hA;
        mode = 0; sel_i = 3'd5; sel_vld = 1; bus.in_vld = 8'b0010_0000; bus.d_i = d; bus.out_ready = 1;
        step("manual_load");
        sel_vld = 0;
        #1;
        n_checks++;
        if (bus.in_ready !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL manual_ready: got %b expected 00100000", bus.in_ready);
        end
        step("manual_cap");
        n_checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 4'hA || bus.out_ch !== 3'd5) begin
            n_fail++;
            $display("FAIL manual_out: got vld=%b data=%h ch=%0d expected 1/a/5",
                     bus.out_vld, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  held;
        logic [31:0] d;
        held = bus.out_data;
        bus.out_ready = 0; bus.in_vld = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bus.d_i = $urandom;
            step("bp_hold");
            n_checks++;
            if (bus.out_data !== held || bus.in_ready !== 8'h0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got data=%h rdy=%b expected data=%h rdy=0",
                         i, bus.out_data, bus.in_ready, held);
            end
        end
        d = $urandom;
        d[23:20] = ~held;
        bus.d_i = d; bus.out_ready = 1;
        #1;
        n_checks++;
        if (bus.in_ready !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 00100000", bus.in_ready);
        end
        step("bp_release");
        n_checks++;
        if (bus.out_data !== ~held || bus.out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_cap: got %h vld=%b expected %h vld=1", bus.out_data, bus.out_vld, ~held);
        end
    endtask

    task automatic test_scan();
        int got_ch[$];
        int got_cyc[$];
        int exp_ch[4]  = '{0, 2, 7, 0};
        int exp_cyc[4] = '{0, 2, 7, 8};
        mode = 1; bus.in_vld = 8'b1000_0101; bus.out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            bus.d_i = $urandom;
            step("scan");
            if (bus.out_vld === 1'b1) begin
                got_ch.push_back(int'(bus.out_ch));
                got_cyc.push_back(c);
            end
        end
        n_checks++;
        if (got_ch.size() < 4) begin
            n_fail++;
            $display("FAIL scan_count: got %0d captures expected at least 4", got_ch.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_ch[i] != exp_ch[i] || got_cyc[i] != exp_cyc[i]) begin
                    n_fail++;
                    $display("FAIL scan_seq%0d: got ch %0d at cycle %0d expected ch %0d at cycle %0d",
                             i, got_ch[i], got_cyc[i], exp_ch[i], exp_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [31:0] d;
        d = $urandom;
        d[23:20] = 4'b1011;
        mode = 0; sel_vld = 0; bus.in_vld = 8'b0010_0000; bus.d_i = d; bus.out_ready = 1;
        step("mode_back");
        n_checks++;
        if (bus.out_vld !== 1'b1 || bus.out_ch !== 3'd5) begin
            n_fail++;
            $display("FAIL mode_sel_retained: got vld=%b ch=%0d expected 1/5", bus.out_vld, bus.out_ch);
        end
`ifdef MUX_PARITY_EN
        n_checks++;
        if (bus.out_par !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_1011: got %b expected 1", bus.out_par);
        end
        d[23:20] = 4'b0011;
        bus.d_i = d;
        step("parity");
        n_checks++;
        if (bus.out_par !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_0011: got %b expected 0", bus.out_par);
        end
`endif
    endtask

    task automatic test_illegal_sel();
        logic [23:0] d6;
        d6 = 24'($urandom);
        bus6.d_i = d6; bus6.in_vld = 6'h3F; bus6.out_ready = 1; mode6 = 0;
        sel_i6 = 3'd3; sel_vld6 = 1;
        @(posedge clk); #2;
        sel_i6 = 3'd7; sel_vld6 = 1;
        @(posedge clk); #2;
        sel_vld6 = 0;
        #1;
        n_checks++;
        if (bus6.in_ready !== 6'b001000) begin
            n_fail++;
            $display("FAIL illegal_sel_ready: got %b expected 001000", bus6.in_ready);
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus6.out_vld !== 1'b1 || bus6.out_ch !== 3'd3 || bus6.out_data !== d6[15:12]) begin
            n_fail++;
            $display("FAIL illegal_sel_cap: got vld=%b ch=%0d data=%h expected 1/3/%h",
                     bus6.out_vld, bus6.out_ch, bus6.out_data, d6[15:12]);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(7) == 0) mode = ~mode;
            sel_i         = 3'($urandom);
            sel_vld       = ($urandom_range(3) == 0);
            bus.in_vld    = 8'($urandom);
            bus.d_i       = $urandom;
            bus.out_ready = ($urandom_range(3) != 0);
            step("random");
        end
    endtask

    task automatic test_reset_mid();
        mode = 0; sel_i = 3'd1; sel_vld = 1; bus.in_vld = 8'hFF; bus.d_i = $urandom; bus.out_ready = 1;
        step("pre_reset");
        sel_vld = 0; bus.out_ready = 0;
        #1;
        n_checks++;
        if (bus.out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_vld: got %b expected 1", bus.out_vld);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== 4'h0 || bus.out_ch !== 3'd0 || bus.in_ready !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got vld=%b data=%h ch=%0d rdy=%b expected all zero",
                     bus.out_vld, bus.out_data, bus.out_ch, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.out_ready = 1;
        step("post_reset");
    endtask

    initial begin
        test_reset();
        test_manual();
        test_backpressure();
        test_scan();
        test_mode_switch();
        test_illegal_sel();
        test_random(400);
        test_reset_mid();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
